// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : div_pkg
//  Purpose : Shared types and constants for the sequential restoring divider.
//  Contents: state_t  - divider control states
//            N_W      - default dividend/quotient width
//            D_W      - default divisor/remainder width
//            DIV0_QUOT- quotient reported for a zero divisor
//  Revision: 1.0  initial release
// ============================================================================
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int N_W = 16;
  localparam int D_W = 8;

  localparam logic [15:0] DIV0_QUOT = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/div_step.sv
`default_nettype none
// ============================================================================
//  Module  : div_step
//  Purpose : One combinational restoring-division step. Shifts the next
//            dividend bit into the partial remainder, compares against the
//            divisor and conditionally subtracts.
//  Ports   : r       in  D_W  current partial remainder (always < divisor)
//            q_in    in  1    next dividend bit (MSB of the Q shift register)
//            divisor in  D_W  nonzero divisor
//            r_next  out D_W  updated partial remainder
//            q_bit   out 1    quotient bit produced by this step
//  Revision: 1.0  initial release
// ============================================================================
module div_step #(
  parameter int D_W = 8
) (
  input  logic [D_W-1:0] r,
  input  logic           q_in,
  input  logic [D_W-1:0] divisor,
  output logic [D_W-1:0] r_next,
  output logic           q_bit
);

  // The trial value needs one extra bit; after the step the remainder is
  // always below the divisor, so it fits back into D_W bits.
  logic [D_W:0] trial;

  always_comb begin
    trial  = {r, q_in};
    q_bit  = (trial >= {1'b0, divisor});
    r_next = q_bit ? D_W'(trial - {1'b0, divisor}) : trial[D_W-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/seq_div16_by8.sv
`default_nettype none
// ============================================================================
//  Module  : seq_div16_by8
//  Purpose : Iterative restoring divider, N_W-bit unsigned dividend by D_W-bit
//            unsigned divisor, one quotient bit per clock, valid/ready on both
//            sides.
//  Ports   : clk         in  1    system clock
//            rst         in  1    synchronous active-high reset
//            in_valid    in  1    operand pair present
//            in_ready    out 1    block can accept an operand pair (IDLE)
//            dividend    in  N_W  unsigned numerator
//            divisor     in  D_W  unsigned denominator
//            out_valid   out 1    result registers hold a valid result (DONE)
//            out_ready   in  1    consumer accepts the result
//            quotient    out N_W  floor(dividend/divisor), all ones on /0
//            remainder   out D_W  dividend mod divisor, dividend LSBs on /0
//            div_by_zero out 1    result came from a zero divisor
//  Revision: 1.0  initial release
// ============================================================================
module seq_div16_by8 #(
  parameter int N_W   = div_pkg::N_W,
  parameter int D_W   = div_pkg::D_W,
  parameter int CNT_W = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N_W-1:0] dividend,
  input  logic [D_W-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N_W-1:0] quotient,
  output logic [D_W-1:0] remainder,
  output logic           div_by_zero
);

  import div_pkg::*;

  if (D_W > N_W) begin : g_bad_widths
    $error("seq_div16_by8: D_W must not exceed N_W");
  end
  if ((2 ** CNT_W) <= N_W) begin : g_bad_counter
    $error("seq_div16_by8: CNT_W too narrow for N_W iterations");
  end

  state_t state, state_next;

  logic [N_W-1:0]   q_sh;     // dividend shifting out of MSB, quotient into LSB
  logic [D_W-1:0]   r_sh;     // partial remainder
  logic [D_W-1:0]   dvsr;
  logic [CNT_W-1:0] cnt;

  logic [D_W-1:0]   step_r;
  logic             step_q;
  logic [N_W-1:0]   q_shifted;

  logic             accept;
  logic             zero_div;
  logic             last_step;

  div_step #(.D_W(D_W)) u_step (
    .r       (r_sh),
    .q_in    (q_sh[N_W-1]),
    .divisor (dvsr),
    .r_next  (step_r),
    .q_bit   (step_q)
  );

  assign q_shifted = {q_sh[N_W-2:0], step_q};
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign accept    = in_ready && in_valid;
  assign zero_div  = (divisor == '0);
  assign last_step = (cnt == '0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (in_valid) state_next = zero_div ? DONE : CALC;
      CALC: if (last_step) state_next = DONE;
      DONE: if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------- datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      q_sh        <= '0;
      r_sh        <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      if (accept) begin
        if (zero_div) begin
          // No iterations needed: the result is fixed by convention.
          quotient    <= {N_W{1'b1}};
          remainder   <= dividend[D_W-1:0];
          div_by_zero <= 1'b1;
        end else begin
          q_sh <= dividend;
          r_sh <= '0;
          dvsr <= divisor;
          cnt  <= CNT_W'(N_W - 1);
        end
      end else if (state == CALC) begin
        q_sh <= q_shifted;
        r_sh <= step_r;
        if (last_step) begin
          quotient    <= q_shifted;
          remainder   <= step_r;
          div_by_zero <= 1'b0;
        end else begin
          cnt <= cnt - 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_div16_by8.sv
`default_nettype none
// ============================================================================
//  Module  : tb_seq_div16_by8
//  Purpose : Self-checking bench for seq_div16_by8. A transaction-level model
//            (plain / and % with a latency countdown) predicts the handshake
//            and result outputs every cycle; directed operations add literal
//            expectations.
//  Revision: 1.0  initial release
// ============================================================================
module tb_seq_div16_by8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  always #5 clk = ~clk;

  seq_div16_by8 dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ model
  // phase: 0 = waiting for operands, 1 = busy, 2 = holding result
  int          m_phase = 0;
  int          m_left  = 0;
  logic [15:0] m_pq, m_q = '0;
  logic [7:0]  m_pr, m_r = '0;
  logic        m_z = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          if (divisor == 8'd0) begin
            m_q = 16'hFFFF; m_r = dividend[7:0]; m_z = 1'b1; m_phase = 2;
          end else begin
            m_pq = dividend / {8'd0, divisor};
            m_pr = 8'(dividend % {8'd0, divisor});
            m_left = 16; m_phase = 1;
          end
        end
        1: begin
          m_left--;
          if (m_left == 0) begin
            m_q = m_pq; m_r = m_pr; m_z = 1'b0; m_phase = 2;
          end
        end
        default: if (out_ready) m_phase = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("in_ready",    32'(in_ready),    32'(m_phase == 0));
      chk("out_valid",   32'(out_valid),   32'(m_phase == 2));
      chk("quotient",    32'(quotient),    32'(m_q));
      chk("remainder",   32'(remainder),   32'(m_r));
      chk("div_by_zero", 32'(div_by_zero), 32'(m_z));
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic tick();
    @(posedge clk); #2;
  endtask

  // lit=1: compare against the supplied literals; lit=0: check the invariant.
  task automatic run_op(input logic [15:0] a, input logic [7:0] b,
                        input logic [15:0] eq, input logic [7:0] er, input bit ez,
                        input bit lit, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 64) begin tick(); n++; end
    chk("wait_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; dividend = a; divisor = b;
    tick();
    // Garbage operands with in_valid high must be ignored while busy.
    dividend = 16'($urandom); divisor = 8'($urandom);
    n = 0;
    while (!out_valid && n < 64) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      tick(); n++;
    end
    chk("latency", 32'(n), (b == 8'd0) ? 32'd0 : 32'd16);
    if (lit) begin
      chk("lit_quotient",  32'(quotient),    32'(eq));
      chk("lit_remainder", 32'(remainder),   32'(er));
      chk("lit_dbz",       32'(div_by_zero), 32'(ez));
    end else begin
      chk("inv_product", 32'(quotient) * 32'(divisor_hold(b)) + 32'(remainder), 32'(a));
      chk("inv_rem_lt",  32'(remainder < b), 32'd1);
    end
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_quot",  32'(quotient),  lit ? 32'(eq) : 32'(quotient_ref(a, b)));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("consumed_valid", 32'(out_valid), 32'd0);
    chk("consumed_ready", 32'(in_ready),  32'd1);
  endtask

  function automatic logic [7:0] divisor_hold(input logic [7:0] b);
    return b;
  endfunction

  function automatic logic [15:0] quotient_ref(input logic [15:0] a, input logic [7:0] b);
    return (b == 8'd0) ? 16'hFFFF : a / {8'd0, b};
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    tick();
    armed = 1'b1;
    tick();
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient",  32'(quotient),  32'd0);
    rst = 1'b0;
    tick();

    run_op(16'd1000,  8'd7,   16'd142,   8'd6,    1'b0, 1'b1, 0);
    run_op(16'd65535, 8'd255, 16'd257,   8'd0,    1'b0, 1'b1, 0);
    run_op(16'd65535, 8'd1,   16'd65535, 8'd0,    1'b0, 1'b1, 0);
    run_op(16'd5,     8'd9,   16'd0,     8'd5,    1'b0, 1'b1, 0);
    run_op(16'h1234,  8'd0,   16'hFFFF,  8'h34,   1'b1, 1'b1, 2);
    run_op(16'd40000, 8'd200, 16'd200,   8'd0,    1'b0, 1'b1, 10);
    run_op(16'd300,   8'd20,  16'd15,    8'd0,    1'b0, 1'b1, 0);

    // Reset during the calculation discards the partial result.
    in_valid = 1'b1; dividend = 16'd1000; divisor = 8'd7;
    tick();
    in_valid = 1'b0;
    repeat (7) tick();
    chk("mid_busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid",  32'(out_valid), 32'd0);
    chk("mid_rst_ready",  32'(in_ready),  32'd1);
    chk("mid_rst_quot",   32'(quotient),  32'd0);
    chk("mid_rst_rem",    32'(remainder), 32'd0);
    repeat (20) begin
      tick();
      chk("mid_no_stale", 32'(out_valid), 32'd0);
    end
    run_op(16'd200, 8'd3, 16'd66, 8'd2, 1'b0, 1'b1, 0);

    for (int k = 0; k < 300; k++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom);
      b = 8'($urandom_range(1, 255));
      if (k == 0) a = 16'd0;
      if (k == 1) a = 16'hFFFF;
      run_op(a, b, 16'd0, 8'd0, 1'b0, 1'b0, k % 3);
    end

    armed = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
